// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared FFT datapath constants (Q8.8) and arbiter state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    localparam logic [WIDTH-1:0] SIN_45  = 16'h00B5;
    localparam logic [WIDTH-1:0] SIN_315 = 16'hFF4B;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first set request at or above
//           ptr, wrapping around.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import fft_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    int w_sum;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        w_sum     = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_sum = int'(ptr) + off;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            if (req[w_sum[PTR_W-1:0]]) begin
                grant_idx = w_sum[PTR_W-1:0];
                any       = 1'b1;
            end
        end
        grant_onehot = '0;
        if (any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mult_arbiter
// Brief   : Round-robin sharing of one sequential Q8.8 multiplier among
//           N_REQ requesters, with a watchdog for a multiplier that hangs.
// Revision: 1.0 - initial release
// ============================================================================
module mult_arbiter
    import fft_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = fft_pkg::WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       mult_inp1,
    output logic [WIDTH-1:0]       mult_inp2,
    output logic                   mult_rst,
    input  logic [WIDTH-1:0]       mult_out,
    input  logic                   mult_stb,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t       r_state, w_state;
    logic [PTR_W-1:0] r_ptr, w_ptr;
    logic [PTR_W-1:0] r_gidx, w_gidx;
    logic [CNT_W-1:0] r_wd, w_wd;
    logic [WIDTH-1:0] r_inp1, w_inp1;
    logic [WIDTH-1:0] r_inp2, w_inp2;
    logic [N_REQ-1:0] r_req_ready, w_req_ready;
    logic [N_REQ-1:0] r_rsp_valid, w_rsp_valid;
    logic             r_rsp_err, w_rsp_err;
    logic [WIDTH-1:0] r_rsp_data, w_rsp_data;

    logic [N_REQ-1:0] w_pick_oh;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic [N_REQ-1:0] w_issuer_oh;
    logic [PTR_W-1:0] w_ptr_inc;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req          (req_valid),
        .ptr          (r_ptr),
        .grant_onehot (w_pick_oh),
        .grant_idx    (w_pick_idx),
        .any          (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_wd        <= '0;
            r_inp1      <= '0;
            r_inp2      <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_gidx      <= w_gidx;
            r_wd        <= w_wd;
            r_inp1      <= w_inp1;
            r_inp2      <= w_inp2;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            r_rsp_data  <= w_rsp_data;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_gidx      = r_gidx;
        w_wd        = r_wd;
        w_inp1      = r_inp1;
        w_inp2      = r_inp2;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_rsp_err   = 1'b0;
        w_rsp_data  = '0;
        w_issuer_oh = '0;
        w_issuer_oh[r_gidx] = 1'b1;
        w_ptr_inc   = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_inp1      = req_a[w_pick_idx*WIDTH +: WIDTH];
                    w_inp2      = req_b[w_pick_idx*WIDTH +: WIDTH];
                    w_req_ready = w_pick_oh;
                    w_gidx      = w_pick_idx;
                    w_wd        = '0;
                    w_state     = RUN;
                end
            end
            RUN: begin
                w_wd = r_wd + 1'b1;
                // A strobe on the last watchdog cycle still counts as success.
                if (mult_stb || (r_wd == CNT_W'(TIMEOUT - 1))) begin
                    w_rsp_valid = w_issuer_oh;
                    w_rsp_err   = ~mult_stb;
                    w_rsp_data  = mult_stb ? mult_out : '0;
                    w_ptr       = w_ptr_inc;
                    w_state     = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // Multiplier is held cleared whenever no job is in flight.
    assign mult_rst  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign mult_inp1 = r_inp1;
    assign mult_inp2 = r_inp2;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_arbiter
// Brief   : Directed bench for mult_arbiter with a latency-programmable
//           Q8.8 multiplier model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult_arbiter;
    import fft_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic [W-1:0]   mult_inp1;
    logic [W-1:0]   mult_inp2;
    logic           mult_rst;
    logic [W-1:0]   mult_out;
    logic           mult_stb;
    logic           busy;

    int tests = 0;
    int fails = 0;

    int lat       = 3;
    bit never_stb = 1'b0;
    int mcnt      = 0;
    logic signed [31:0] prod;

    mult_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mult_inp1 (mult_inp1),
        .mult_inp2 (mult_inp2),
        .mult_rst  (mult_rst),
        .mult_out  (mult_out),
        .mult_stb  (mult_stb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: counts RUN cycles since mult_rst fell.
    always @(posedge clk) begin
        if (mult_rst) mcnt <= 0;
        else          mcnt <= mcnt + 1;
    end
    assign prod     = $signed(mult_inp1) * $signed(mult_inp2);
    assign mult_out = prod[23:8];
    assign mult_stb = !mult_rst && !never_stb && (mcnt == lat - 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Expects req_valid already driven; returns in the response cycle.
    task automatic run_job(input string tag, input int idx, input int run_cyc, input bit keep,
                           input logic [15:0] exp_data, input bit exp_err);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        tick();
        check({tag, " ready"}, 32'(req_ready), 32'(oh));
        check({tag, " mult_rst low"}, 32'(mult_rst), 32'd0);
        check({tag, " inp1"}, 32'(mult_inp1), 32'(req_a[idx*W +: W]));
        check({tag, " inp2"}, 32'(mult_inp2), 32'(req_b[idx*W +: W]));
        if (!keep) req_valid[idx] = 1'b0;
        for (int c = 1; c < run_cyc; c++) begin
            tick();
            check({tag, " no rsp"}, 32'(rsp_valid), 32'd0);
            check({tag, " run mult_rst"}, 32'(mult_rst), 32'd0);
        end
        tick();
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, " mult_rst high"}, 32'(mult_rst), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst rsp_data", 32'(rsp_data), 32'd0);
        check("rst inp1", 32'(mult_inp1), 32'd0);
        check("rst inp2", 32'(mult_inp2), 32'd0);
        check("rst mult_rst", 32'(mult_rst), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("idle no grant", 32'(req_ready), 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        // Single request, 1.5 * 2.0
        lat = 3;
        set_op(2, 16'h0180, 16'h0200);
        req_valid = 4'b0100;
        run_job("single", 2, 3, 1'b0, 16'h0300, 1'b0);
        tick();
        check("single pulse rsp", 32'(rsp_valid), 32'd0);
        check("single pulse rdy", 32'(req_ready), 32'd0);

        // Fairness: grant 1, then 0 and 3 together -> 3 first
        lat = 2;
        set_op(1, 16'h0280, 16'h0100);
        req_valid = 4'b0010;
        run_job("fair r1", 1, 2, 1'b0, 16'h0280, 1'b0);
        set_op(0, 16'h0040, 16'h0400);
        set_op(3, 16'h0100, SIN_45);
        req_valid = 4'b1001;
        run_job("fair r3", 3, 2, 1'b0, 16'h00B5, 1'b0);
        run_job("fair r0", 0, 2, 1'b0, 16'h0100, 1'b0);

        // Continuous contention from reset
        rst = 1'b1;
        req_valid = 4'hF;
        set_op(0, 16'h0100, 16'h0200);
        set_op(1, 16'h0200, 16'h0200);
        set_op(2, 16'h0300, 16'h0200);
        set_op(3, 16'h0400, 16'h0200);
        tick();
        check("cont rst ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        run_job("cont0", 0, 2, 1'b1, 16'h0200, 1'b0);
        run_job("cont1", 1, 2, 1'b1, 16'h0400, 1'b0);
        run_job("cont2", 2, 2, 1'b1, 16'h0600, 1'b0);
        run_job("cont3", 3, 2, 1'b1, 16'h0800, 1'b0);
        run_job("cont0b", 0, 2, 1'b1, 16'h0200, 1'b0);

        // Timeout with a silent multiplier, then a normal job
        never_stb = 1'b1;
        set_op(1, 16'h0100, 16'h0100);
        req_valid = 4'b0010;
        run_job("timeout", 1, TO, 1'b0, 16'h0000, 1'b1);
        never_stb = 1'b0;
        lat = 3;
        set_op(2, 16'h0180, 16'h0200);
        req_valid = 4'b0100;
        run_job("after timeout", 2, 3, 1'b0, 16'h0300, 1'b0);

        // Strobe on the last watchdog cycle, -0.5 * 3.0
        lat = 16;
        set_op(3, 16'hFF80, 16'h0300);
        req_valid = 4'b1000;
        run_job("race", 3, 16, 1'b0, 16'hFE80, 1'b0);

        // Move ptr to 1, then reset in the middle of a job on requester 2
        lat = 2;
        set_op(0, 16'h0100, 16'h0100);
        req_valid = 4'b0001;
        run_job("pre rst", 0, 2, 1'b0, 16'h0100, 1'b0);
        lat = 8;
        set_op(2, 16'h0300, 16'h0300);
        req_valid = 4'b0100;
        tick();
        check("mid grant", 32'(req_ready), 32'b0100);
        req_valid = '0;
        tick();
        tick();
        check("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid mult_rst", 32'(mult_rst), 32'd1);
        check("mid busy clr", 32'(busy), 32'd0);
        check("mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid req_ready", 32'(req_ready), 32'd0);
        check("mid rsp_data", 32'(rsp_data), 32'd0);
        check("mid rsp_err", 32'(rsp_err), 32'd0);
        check("mid inp1", 32'(mult_inp1), 32'd0);
        check("mid inp2", 32'(mult_inp2), 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("mid dropped", 32'(rsp_valid), 32'd0);
        end
        lat = 2;
        req_valid = 4'b1001;
        run_job("post rst r0", 0, 2, 1'b0, 16'h0100, 1'b0);
        run_job("post rst r3", 3, 2, 1'b0, 16'hFE80, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
